// File: rtl/flit_assembler_16_to_32_bit_pkg.sv
// Shared bridge package: flit width constants, buffer sizing and FSM state types
// for the 16-to-32 assembler and its 32-to-16 counterpart.
package flit_assembler_16_to_32_bit_pkg;

  localparam int FLIT16_WIDTH = 16;
  localparam int FLIT32_WIDTH = 32;

  // Each buffered word carries {flit_16, last} above the 32-bit payload.
  localparam int WORD_META_BITS = 2;

  typedef enum logic {
    LOWER_HALF = 1'b0,
    UPPER_HALF = 1'b1
  } asm_state_t;

  typedef enum logic {
    SPLIT_LOWER = 1'b0,
    SPLIT_UPPER = 1'b1
  } split_state_t;

  function automatic int buffer_depth(input int max_pkt_len);
    return 1 << $clog2(max_pkt_len + 1);
  endfunction

endpackage

// File: rtl/noc_buffer.sv
// Synchronous valid/ready FIFO with power-of-two depth; a push is refused while
// full even if a pop happens in the same cycle.
module noc_buffer #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

endmodule

// File: rtl/flit_assembler_16_to_32_bit.sv
// Packs pairs of 16-bit flits into 32-bit flits behind a packet-sized FIFO.
// Define FLIT_ASSEMBLER_STORE_AND_FORWARD_EN to hold output until a whole packet is buffered.
module flit_assembler_16_to_32_bit
  import flit_assembler_16_to_32_bit_pkg::*;
#(
  parameter int MAX_PKT_LEN = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_flit_data,
  input  logic        in_flit_valid,
  input  logic        in_flit_last,
  output logic        in_flit_ready,
  output logic [31:0] out_flit_data,
  output logic        out_flit_valid,
  output logic        out_flit_last,
  output logic        out_flit_16,
  input  logic        out_flit_ready
);

  localparam int IN_FLIT_WIDTH  = FLIT16_WIDTH;
  localparam int OUT_FLIT_WIDTH = FLIT32_WIDTH;
  localparam int FIFO_DEPTH     = buffer_depth(MAX_PKT_LEN);
  localparam int WORD_WIDTH     = OUT_FLIT_WIDTH + WORD_META_BITS;

  asm_state_t               state;
  logic [IN_FLIT_WIDTH-1:0] half_reg;
  logic                     accept;
  logic                     push;
  logic [WORD_WIDTH-1:0]    push_word;
  logic [WORD_WIDTH-1:0]    pop_word;
  logic                     buf_in_ready;
  logic                     buf_out_valid;
  logic                     buf_out_ready;

  // A non-last lower half only lands in half_reg, so it never waits on the FIFO.
  always_comb begin
    in_flit_ready = 1'b0;
    if (!rst) begin
      if (state == LOWER_HALF && !in_flit_last) in_flit_ready = 1'b1;
      else                                      in_flit_ready = buf_in_ready;
    end
  end

  assign accept = in_flit_valid && in_flit_ready;
  assign push   = accept && ((state == UPPER_HALF) || in_flit_last);

  always_comb begin
    push_word = {1'b1, 1'b1, {IN_FLIT_WIDTH{1'b0}}, in_flit_data};
    if (state == UPPER_HALF) push_word = {1'b0, in_flit_last, in_flit_data, half_reg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOWER_HALF;
      half_reg <= '0;
    end else if (accept) begin
      case (state)
        LOWER_HALF: begin
          if (!in_flit_last) begin
            half_reg <= in_flit_data;
            state    <= UPPER_HALF;
          end
        end
        UPPER_HALF: state <= LOWER_HALF;
        default:    state <= LOWER_HALF;
      endcase
    end
  end

  noc_buffer #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .in_data   (push_word),
    .in_valid  (push),
    .in_ready  (buf_in_ready),
    .out_data  (pop_word),
    .out_valid (buf_out_valid),
    .out_ready (buf_out_ready)
  );

  assign out_flit_data = pop_word[OUT_FLIT_WIDTH-1:0];
  assign out_flit_last = pop_word[OUT_FLIT_WIDTH];
  assign out_flit_16   = pop_word[OUT_FLIT_WIDTH+1];

`ifdef FLIT_ASSEMBLER_STORE_AND_FORWARD_EN
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [CNT_W-1:0] pkt_count;
  logic             release_out;
  logic             push_last;
  logic             pop_last;

  // A full FIFO with no complete packet is an overlength packet: let it cut through.
  assign release_out    = (pkt_count != '0) || !buf_in_ready;
  assign out_flit_valid = buf_out_valid && release_out;
  assign buf_out_ready  = out_flit_ready && release_out;
  assign push_last      = push && push_word[OUT_FLIT_WIDTH];
  assign pop_last       = out_flit_valid && out_flit_ready && out_flit_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
    end else if (push_last && !pop_last) begin
      pkt_count <= pkt_count + 1'b1;
    end else if (pop_last && !push_last) begin
      pkt_count <= pkt_count - 1'b1;
    end
  end
`else
  assign out_flit_valid = buf_out_valid;
  assign buf_out_ready  = out_flit_ready;
`endif

endmodule
